// File: rtl/tennis_score_keeper.sv
// Tennis scoring stage: turns rally-won pulses into points, games,
// server tracking and match result for the display driver.
module tennis_score_keeper #(
    parameter int GAMES_TO_WIN = 6,
    parameter int GAME_W       = 4
) (
    input  logic              clk,
    input  logic              reset_clk,
    input  logic              point_p1,
    input  logic              point_p2,
    input  logic              new_match,
    output logic [2:0]        p1_pts,
    output logic [2:0]        p2_pts,
    output logic [GAME_W-1:0] p1_games,
    output logic [GAME_W-1:0] p2_games,
    output logic              deuce,
    output logic              adv_p1,
    output logic              adv_p2,
    output logic              game_won,
    output logic              game_winner,
    output logic              serve,
    output logic              match_over,
    output logic              match_winner,
    output logic              conflict
);

    localparam logic [2:0] PT_40 = 3'd3;
    localparam logic [2:0] PT_AD = 3'd4;
    localparam logic [GAME_W-1:0] GAMES_MAX = GAME_W'(GAMES_TO_WIN);

    logic [2:0]        p1_pts_q, p1_pts_d;
    logic [2:0]        p2_pts_q, p2_pts_d;
    logic [GAME_W-1:0] p1_games_q, p1_games_d;
    logic [GAME_W-1:0] p2_games_q, p2_games_d;
    logic              deuce_q, deuce_d;
    logic              adv_p1_q, adv_p1_d;
    logic              adv_p2_q, adv_p2_d;
    logic              game_won_q, game_won_d;
    logic              game_winner_q, game_winner_d;
    logic              serve_q, serve_d;
    logic              match_over_q, match_over_d;
    logic              match_winner_q, match_winner_d;
    logic              conflict_q, conflict_d;

    // Scorer-relative view: x is the rally winner, y the opponent
    logic              win_p2;
    logic [2:0]        x_pts, y_pts;
    logic [2:0]        x_nxt, y_nxt;
    logic              x_game;
    logic              illegal;
    logic [GAME_W-1:0] x_games, x_games_inc;

    always_comb begin
        win_p2      = point_p2;
        x_pts       = point_p2 ? p2_pts_q : p1_pts_q;
        y_pts       = point_p2 ? p1_pts_q : p2_pts_q;
        x_games     = point_p2 ? p2_games_q : p1_games_q;
        x_games_inc = x_games + GAME_W'(1);
        x_nxt       = x_pts;
        y_nxt       = y_pts;
        x_game      = 1'b0;
        illegal     = (x_pts > PT_AD) || (y_pts > PT_AD) ||
                      ((x_pts == PT_AD) && (y_pts == PT_AD));

        if (illegal) begin
            x_nxt = 3'd0;
            y_nxt = 3'd0;
        end else if (x_pts < PT_40) begin
            x_nxt = x_pts + 3'd1;
        end else if (x_pts == PT_40) begin
            if (y_pts < PT_40) begin
                x_game = 1'b1;
            end else if (y_pts == PT_40) begin
                x_nxt = PT_AD;
            end else begin
                y_nxt = PT_40;
            end
        end else begin
            x_game = 1'b1;
        end

        if (x_game) begin
            x_nxt = 3'd0;
            y_nxt = 3'd0;
        end
    end

    always_comb begin
        p1_pts_d       = p1_pts_q;
        p2_pts_d       = p2_pts_q;
        p1_games_d     = p1_games_q;
        p2_games_d     = p2_games_q;
        game_won_d     = 1'b0;
        game_winner_d  = game_winner_q;
        serve_d        = serve_q;
        match_over_d   = match_over_q;
        match_winner_d = match_winner_q;
        conflict_d     = 1'b0;

        if (new_match) begin
            p1_pts_d       = 3'd0;
            p2_pts_d       = 3'd0;
            p1_games_d     = '0;
            p2_games_d     = '0;
            game_winner_d  = 1'b0;
            serve_d        = 1'b0;
            match_over_d   = 1'b0;
            match_winner_d = 1'b0;
        end else if (!match_over_q) begin
            if (point_p1 && point_p2) begin
                conflict_d = 1'b1;
            end else if (point_p1 || point_p2) begin
                p1_pts_d = win_p2 ? y_nxt : x_nxt;
                p2_pts_d = win_p2 ? x_nxt : y_nxt;
                if (x_game) begin
                    game_won_d    = 1'b1;
                    game_winner_d = win_p2;
                    if (win_p2) begin
                        p2_games_d = x_games_inc;
                    end else begin
                        p1_games_d = x_games_inc;
                    end
                    // Server stays put on the match-winning game
                    if (x_games_inc == GAMES_MAX) begin
                        match_over_d   = 1'b1;
                        match_winner_d = win_p2;
                    end else begin
                        serve_d = ~serve_q;
                    end
                end
            end
        end

        deuce_d  = (p1_pts_d == PT_40) && (p2_pts_d == PT_40);
        adv_p1_d = (p1_pts_d == PT_AD);
        adv_p2_d = (p2_pts_d == PT_AD);
    end

    always_ff @(posedge clk or negedge reset_clk) begin
        if (!reset_clk) begin
            p1_pts_q       <= 3'd0;
            p2_pts_q       <= 3'd0;
            p1_games_q     <= '0;
            p2_games_q     <= '0;
            deuce_q        <= 1'b0;
            adv_p1_q       <= 1'b0;
            adv_p2_q       <= 1'b0;
            game_won_q     <= 1'b0;
            game_winner_q  <= 1'b0;
            serve_q        <= 1'b0;
            match_over_q   <= 1'b0;
            match_winner_q <= 1'b0;
            conflict_q     <= 1'b0;
        end else begin
            p1_pts_q       <= p1_pts_d;
            p2_pts_q       <= p2_pts_d;
            p1_games_q     <= p1_games_d;
            p2_games_q     <= p2_games_d;
            deuce_q        <= deuce_d;
            adv_p1_q       <= adv_p1_d;
            adv_p2_q       <= adv_p2_d;
            game_won_q     <= game_won_d;
            game_winner_q  <= game_winner_d;
            serve_q        <= serve_d;
            match_over_q   <= match_over_d;
            match_winner_q <= match_winner_d;
            conflict_q     <= conflict_d;
        end
    end

    assign p1_pts       = p1_pts_q;
    assign p2_pts       = p2_pts_q;
    assign p1_games     = p1_games_q;
    assign p2_games     = p2_games_q;
    assign deuce        = deuce_q;
    assign adv_p1       = adv_p1_q;
    assign adv_p2       = adv_p2_q;
    assign game_won     = game_won_q;
    assign game_winner  = game_winner_q;
    assign serve        = serve_q;
    assign match_over   = match_over_q;
    assign match_winner = match_winner_q;
    assign conflict     = conflict_q;

endmodule

// File: tb/tb_tennis_score_keeper.sv
// Directed bench for tennis_score_keeper with hand-computed scores.
module tb_tennis_score_keeper;

    logic       clk = 1'b0;
    logic       reset_clk = 1'b0;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       new_match = 1'b0;
    logic [2:0] p1_pts, p2_pts;
    logic [3:0] p1_games, p2_games;
    logic       deuce, adv_p1, adv_p2, game_won, game_winner;
    logic       serve, match_over, match_winner, conflict;

    int checks = 0;
    int errors = 0;

    tennis_score_keeper #(.GAMES_TO_WIN(6), .GAME_W(4)) dut (
        .clk(clk), .reset_clk(reset_clk),
        .point_p1(point_p1), .point_p2(point_p2),
        .new_match(new_match),
        .p1_pts(p1_pts), .p2_pts(p2_pts),
        .p1_games(p1_games), .p2_games(p2_games),
        .deuce(deuce), .adv_p1(adv_p1), .adv_p2(adv_p2),
        .game_won(game_won), .game_winner(game_winner),
        .serve(serve), .match_over(match_over),
        .match_winner(match_winner), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic score(input string tag, input int e1, input int e2,
                         input int eg1, input int eg2, input int esv);
        chk({tag, ".p1_pts"}, p1_pts, e1);
        chk({tag, ".p2_pts"}, p2_pts, e2);
        chk({tag, ".p1_games"}, p1_games, eg1);
        chk({tag, ".p2_games"}, p2_games, eg2);
        chk({tag, ".serve"}, serve, esv);
    endtask

    task automatic flags(input string tag, input int ed, input int ea1,
                         input int ea2, input int egw, input int ecf);
        chk({tag, ".deuce"}, deuce, ed);
        chk({tag, ".adv_p1"}, adv_p1, ea1);
        chk({tag, ".adv_p2"}, adv_p2, ea2);
        chk({tag, ".game_won"}, game_won, egw);
        chk({tag, ".conflict"}, conflict, ecf);
    endtask

    task automatic all_zero(input string tag);
        score(tag, 0, 0, 0, 0, 0);
        flags(tag, 0, 0, 0, 0, 0);
        chk({tag, ".game_winner"}, game_winner, 0);
        chk({tag, ".match_over"}, match_over, 0);
        chk({tag, ".match_winner"}, match_winner, 0);
    endtask

    task automatic pt(input logic a, input logic b);
        @(negedge clk);
        point_p1 = a;
        point_p2 = b;
        @(posedge clk);
        #1;
        point_p1 = 1'b0;
        point_p2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic straight(input logic who);
        repeat (4) pt(!who, who);
    endtask

    initial begin
        #2;
        all_zero("in_reset");
        @(negedge clk);
        reset_clk = 1'b1;
        idle(1);

        pt(1, 0);
        pt(1, 0);
        chk("pre_reset.p1_pts", p1_pts, 2);
        #2;
        reset_clk = 1'b0;
        #1;
        all_zero("async_reset");
        @(negedge clk);
        reset_clk = 1'b1;
        idle(2);
        all_zero("post_release");

        pt(1, 0);
        chk("sg1.p1_pts", p1_pts, 1);
        idle(2);
        pt(1, 0);
        chk("sg2.p1_pts", p1_pts, 2);
        idle(2);
        pt(1, 0);
        score("sg3", 3, 0, 0, 0, 0);
        flags("sg3", 0, 0, 0, 0, 0);
        idle(2);
        pt(1, 0);
        score("sg4", 0, 0, 1, 0, 1);
        flags("sg4", 0, 0, 0, 1, 0);
        chk("sg4.game_winner", game_winner, 0);
        idle(1);
        chk("sg4.game_won_drop", game_won, 0);

        repeat (3) pt(1, 0);
        repeat (3) pt(0, 1);
        score("deuce1", 3, 3, 1, 0, 1);
        flags("deuce1", 1, 0, 0, 0, 0);
        pt(0, 1);
        score("adv2", 3, 4, 1, 0, 1);
        flags("adv2", 0, 0, 1, 0, 0);
        pt(1, 0);
        score("deuce2", 3, 3, 1, 0, 1);
        flags("deuce2", 1, 0, 0, 0, 0);
        pt(1, 0);
        score("adv1", 4, 3, 1, 0, 1);
        flags("adv1", 0, 1, 0, 0, 0);
        pt(1, 0);
        score("deuce_game", 0, 0, 2, 0, 0);
        flags("deuce_game", 0, 0, 0, 1, 0);
        chk("deuce_game.winner", game_winner, 0);

        pt(1, 0);
        pt(1, 0);
        pt(0, 1);
        pt(1, 1);
        score("conflict", 2, 1, 2, 0, 0);
        flags("conflict", 0, 0, 0, 0, 1);
        idle(1);
        chk("conflict_drop", conflict, 0);
        @(negedge clk);
        new_match = 1'b1;
        point_p1 = 1'b1;
        @(posedge clk);
        #1;
        new_match = 1'b0;
        point_p1 = 1'b0;
        all_zero("nm_with_point");

        for (int k = 1; k <= 6; k++) begin
            straight(1'b1);
            score($sformatf("m%0d", k), 0, 0, 0, k, (k < 6) ? k % 2 : 1);
            chk($sformatf("m%0d.game_won", k), game_won, 1);
            chk($sformatf("m%0d.winner", k), game_winner, 1);
            chk($sformatf("m%0d.match_over", k), match_over, (k == 6) ? 1 : 0);
        end
        chk("match.match_winner", match_winner, 1);
        pt(1, 0);
        pt(0, 1);
        pt(1, 1);
        score("locked", 0, 0, 0, 6, 1);
        flags("locked", 0, 0, 0, 0, 0);
        chk("locked.match_over", match_over, 1);
        chk("locked.match_winner", match_winner, 1);
        @(negedge clk);
        new_match = 1'b1;
        @(posedge clk);
        #1;
        new_match = 1'b0;
        all_zero("nm_after_match");

        for (int k = 1; k <= 5; k++) begin
            straight(k % 2 == 0);
            chk($sformatf("alt%0d.serve", k), serve, k % 2);
            chk($sformatf("alt%0d.winner", k), game_winner, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("alt%0d.game_won", k), game_won, 1);
        end
        score("alt_end", 0, 0, 3, 2, 1);
        chk("alt_end.match_over", match_over, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tennis_score_keeper.md
Name: tennis_score_keeper

Overview:
Downstream stage of the ball-movement/LED logic in `top`. It consumes single-cycle "rally won" pulses from the ball mover and keeps a standard tennis score: points 0/15/30/40/AD, deuce and advantage, games per player, match winner. It also tracks the server, alternating each game. All outputs are registered and feed the display/LED driver.

Parameters:
GAMES_TO_WIN, 6, games needed to win the match (no tiebreak, no two-game margin)
GAME_W, 4, width of each games counter; must hold GAMES_TO_WIN

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_clk  input  1  asynchronous, active-low reset; 0 clears all state immediately
point_p1  input  1  synchronous pulse from ball mover: player 1 won the rally
point_p2  input  1  synchronous pulse from ball mover: player 2 won the rally
new_match  input  1  synchronous clear of the whole score; highest priority after reset
p1_pts  output  3  player 1 point code: 0=0, 1=15, 2=30, 3=40, 4=AD
p2_pts  output  3  player 2 point code, same encoding
p1_games  output  GAME_W  games won by player 1
p2_games  output  GAME_W  games won by player 2
deuce  output  1  high while p1_pts==3 and p2_pts==3
adv_p1  output  1  high while p1_pts==4
adv_p2  output  1  high while p2_pts==4
game_won  output  1  one-cycle pulse in the cycle a game's totals update
game_winner  output  1  0=player 1, 1=player 2; holds the last game winner
serve  output  1  current server, 0=player 1, 1=player 2
match_over  output  1  high from the winning game until new_match or reset
match_winner  output  1  valid while match_over; 0=player 1, 1=player 2
conflict  output  1  one-cycle pulse when point_p1 and point_p2 are both high

Behaviour:
- Reset (reset_clk=0, asynchronous): every output and internal register is 0. This means pts 0/0, games 0/0, serve=0, all flags and pulses low. Release is synchronous to the next clk edge.
- Event priority each cycle:
  - new_match: same clear as reset, but synchronous.
  - match_over=1: point inputs ignored, no conflict pulse.
  - point_p1 and point_p2 both high: score unchanged; conflict=1 for that cycle.
  - Exactly one point input high: score a point for that player (X; opponent Y).
  - No input: hold state.
- Each cycle an input is high counts as one point. Upstream guarantees single-cycle pulses; there is no internal edge detection.
- Point FSM for X, with Y as the other player's code:
  - X<=2: X=X+1.
  - X==3 and Y<=2: game to X.
  - X==3 and Y==3: X=4 (advantage X).
  - X==3 and Y==4: Y=3 (back to deuce); X stays 3.
  - X==4: game to X.
- Game to X, registered on the same edge:
  - Both pts go to 0.
  - X games counter increments.
  - game_won=1 for exactly that cycle.
  - game_winner=X.
  - serve toggles.
- If X's new games count equals GAMES_TO_WIN:
  - match_over=1 and match_winner=X on the same edge.
  - serve does not toggle on the match-winning game.
  - Games counters saturate; they never increment while match_over.
- deuce, adv_p1 and adv_p2 are registered, decoded from next-state pts. They are valid in the same cycle as the new pts value.
- Latency: 1 clk from input pulse to updated outputs. No back-pressure and no handshake beyond the pulses.
- Illegal states (pts 5–7; both pts 4): next valid point input forces both pts to 0 without awarding a game. Unreachable in normal operation.

Test Plan:
- Reset: drive reset_clk=0 mid-rally with p1_pts=2 and no clk edge -> all outputs 0 immediately. After release plus 2 idle cycles, outputs are still 0.
- Straight game: 4 single-cycle point_p1 pulses spaced 3 cycles -> p1_pts goes 1, 2, 3. On the 4th: p1_pts=0, p1_games=1, game_won high 1 cycle, game_winner=0, serve=1.
- Deuce cycle: reach 3/3 -> deuce=1. point_p2 -> p2_pts=4, adv_p2=1, deuce=0. point_p1 -> 3/3, deuce=1. point_p1, point_p1 -> p1_games+1, pts 0/0.
- Conflict: at p1_pts=2, p2_pts=1, assert both inputs for 1 cycle -> pts unchanged and conflict=1 for 1 cycle. new_match asserted together with point_p1 -> full clear, no point.
- Match: player 2 wins 6 straight games -> match_over=1, match_winner=1, p2_games=6. Further point_p1/point_p2 -> no change. new_match -> all 0.
- Serve tracking: alternate game winners for 5 games -> serve toggles every game and game_winner follows the winner each time.
